// File: rtl/count_seq_checker_pkg.sv
// count_mon_pkg: shared types and helpers for the count sequence checker
package count_mon_pkg;

   typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

   typedef enum logic [1:0] {REL_NONE, REL_LAG, REL_SAME, REL_OTHER} rel_t;

   // +1 at full width; callers truncate to their own width so the carry is dropped
   function automatic logic [31:0] next_count(input logic [31:0] v);
      return v + 32'd1;
   endfunction

endpackage

// File: rtl/count_seq_checker.sv
// count_seq_checker: locks onto a +1 count stream, counts and captures discontinuities
module count_seq_checker
   import count_mon_pkg::*;
#(
   parameter int W      = 8,
   parameter int LOCK_N = 4,
   parameter int ERR_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [W-1:0]     in_count,
   input  logic [W-1:0]     in_prev,
   input  logic             clr,
   output logic             locked,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_count,
   output logic [W-1:0]     first_bad,
   output logic             first_bad_vld,
   output rel_t             rel
);

   state_t       state;
   logic [7:0]   run;
   logic [W-1:0] last;
   logic         good;
   logic         err_det;
   rel_t         rel_nx;

   // step check against the previous sample, error only counts while locked
   always_comb begin
      good    = in_count == W'(next_count(32'(last)));
      err_det = in_valid && state == LOCKED && !good;
      rel_nx  = (in_prev == in_count - W'(1)) ? REL_LAG :
                (in_prev == in_count)         ? REL_SAME : REL_OTHER;
   end

   // acquisition FSM with registered status outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst || clr) begin
         state         <= IDLE;
         run           <= '0;
         last          <= '0;
         locked        <= 1'b0;
         err_pulse     <= 1'b0;
         first_bad     <= '0;
         first_bad_vld <= 1'b0;
         rel           <= REL_NONE;
      end else begin
         err_pulse <= err_det;
         if (in_valid) begin
            last <= in_count;
            rel  <= rel_nx;
            case (state)
               IDLE: begin
                  state <= ACQUIRE;
                  run   <= '0;
               end
               ACQUIRE: begin
                  if (good) begin
                     run <= run + 8'd1;
                     if (run + 8'd1 == 8'(LOCK_N)) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                     end
                  end else begin
                     run <= '0;
                  end
               end
               LOCKED: begin
                  if (!good) begin
                     state  <= ACQUIRE;
                     run    <= '0;
                     locked <= 1'b0;
                     if (!first_bad_vld) begin
                        first_bad     <= in_count;
                        first_bad_vld <= 1'b1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // saturating discontinuity counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst || clr)
         err_count <= '0;
      else if (err_det && err_count != '1)
         err_count <= err_count + ERR_W'(1);
   end

endmodule

// File: tb/tb_count_seq_checker.sv
// tb_count_seq_checker: randomized and directed check against a behavioural model
module tb_count_seq_checker;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_count = '0;
   logic [7:0] in_prev = '0;
   logic       clr = 1'b0;
   logic        locked, err_pulse, first_bad_vld;
   logic [15:0] err_count;
   logic [7:0]  first_bad;
   logic [1:0]  rel;
   logic        locked2, err_pulse2, first_bad_vld2;
   logic [1:0]  err_count2;
   logic [7:0]  first_bad2;
   logic [1:0]  rel2;

   int tests = 0;
   int fails = 0;

   count_seq_checker #(.W(8), .LOCK_N(4), .ERR_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_count(in_count), .in_prev(in_prev),
      .clr(clr), .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
      .first_bad(first_bad), .first_bad_vld(first_bad_vld), .rel(rel));

   count_seq_checker #(.W(8), .LOCK_N(4), .ERR_W(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_count(in_count), .in_prev(in_prev),
      .clr(clr), .locked(locked2), .err_pulse(err_pulse2), .err_count(err_count2),
      .first_bad(first_bad2), .first_bad_vld(first_bad_vld2), .rel(rel2));

   always #5 clk = ~clk;

   // behavioural model: baseline flag, good-step run length, error bookkeeping
   bit m_have, m_locked, m_pulse, m_fbv;
   int m_run, m_last, m_rel, m_err, m_err2, m_fb, m_pulses;

   always @(posedge clk or posedge rst) begin
      if (rst || clr) begin
         m_have = 0; m_locked = 0; m_pulse = 0; m_fbv = 0;
         m_run = 0; m_last = 0; m_rel = 0; m_err = 0; m_err2 = 0; m_fb = 0;
      end else begin
         m_pulse = 0;
         if (in_valid) begin
            int c, p;
            bit ok;
            c  = int'(in_count);
            p  = int'(in_prev);
            ok = c == (m_last + 1) % 256;
            m_rel = (p == (c + 255) % 256) ? 1 : (p == c) ? 2 : 3;
            if (!m_have) begin
               m_have = 1;
               m_run  = 0;
            end else if (m_locked) begin
               if (!ok) begin
                  m_pulse  = 1;
                  m_pulses++;
                  m_err    = (m_err < 65535) ? m_err + 1 : m_err;
                  m_err2   = (m_err2 < 3) ? m_err2 + 1 : m_err2;
                  if (!m_fbv) begin m_fb = c; m_fbv = 1; end
                  m_locked = 0;
                  m_run    = 0;
               end
            end else if (ok) begin
               m_run++;
               if (m_run == 4) m_locked = 1;
            end else begin
               m_run = 0;
            end
            m_last = c;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // per-cycle comparison of both instances against the model
   always @(negedge clk) begin
      chk("locked", int'(locked), int'(m_locked));
      chk("err_pulse", int'(err_pulse), int'(m_pulse));
      chk("err_count", int'(err_count), m_err);
      chk("first_bad", int'(first_bad), m_fb);
      chk("first_bad_vld", int'(first_bad_vld), int'(m_fbv));
      chk("rel", int'(rel), m_rel);
      chk("locked2", int'(locked2), int'(m_locked));
      chk("err_pulse2", int'(err_pulse2), int'(m_pulse));
      chk("err_count2", int'(err_count2), m_err2);
   end

   task automatic smp(input int c, input int p);
      @(negedge clk);
      in_valid = 1'b1;
      in_count = 8'(c % 256);
      in_prev  = 8'((p + 256) % 256);
      @(posedge clk);
      #1;
   endtask

   task automatic gap(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_clr();
      @(negedge clk);
      in_valid = 1'b0;
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
   endtask

   initial begin
      int b, lastd, c, p;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_locked", int'(locked), 0);
      chk("rst_err", int'(err_count), 0);
      chk("rst_rel", int'(rel), 0);

      for (int i = 0; i < 6; i++) begin
         smp(i, i - 1);
         if (i == 3) chk("not_yet_locked", int'(locked), 0);
         if (i == 4) chk("locked_after_4_steps", int'(locked), 1);
      end
      chk("lag_rel", int'(rel), 1);
      chk("no_err", int'(err_count), 0);

      for (int i = 6; i < 12; i++) smp(i, i - 1);
      smp(13, 12);
      chk("gap_pulse", int'(err_pulse), 1);
      chk("gap_err", int'(err_count), 1);
      chk("gap_first_bad", int'(first_bad), 13);
      chk("gap_unlock", int'(locked), 0);
      smp(14, 13);
      chk("pulse_one_cycle", int'(err_pulse), 0);
      for (int i = 15; i < 18; i++) smp(i, i - 1);
      chk("relock", int'(locked), 1);

      do_clr();
      for (int i = 252; i < 258; i++) smp(i, i);
      chk("wrap_locked", int'(locked), 1);
      chk("wrap_err", int'(err_count), 0);
      chk("wrap_rel", int'(rel), 2);
      for (int i = 2; i < 21; i++) smp(i, i - 1);
      gap(3);
      smp(21, 20);
      chk("invalid_gap_no_err", int'(err_count), 0);
      chk("invalid_gap_locked", int'(locked), 1);
      smp(21, 20);
      chk("repeat_err", int'(err_count), 1);
      chk("repeat_first_bad", int'(first_bad), 21);
      for (int i = 22; i < 26; i++) smp(i, i - 1);
      smp(30, 29);
      chk("second_err", int'(err_count), 2);
      chk("first_bad_kept", int'(first_bad), 21);

      b = 30;
      repeat (3) begin
         for (int j = 1; j < 5; j++) smp(b + j, b + j - 1);
         b = b + 15;
         smp(b, 0);
      end
      chk("err_five", int'(err_count), 5);
      chk("err_sat", int'(err_count2), 3);

      do_clr();
      for (int i = 0; i < 5; i++) smp(i, i - 1);
      smp(9, 8);
      for (int i = 10; i < 14; i++) smp(i, i - 1);
      smp(20, 19);
      for (int i = 21; i < 25; i++) smp(i, i - 1);
      chk("pre_rst_err", int'(err_count), 2);
      chk("pre_rst_locked", int'(locked), 1);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("async_locked", int'(locked), 0);
      chk("async_err", int'(err_count), 0);
      chk("async_fbv", int'(first_bad_vld), 0);
      chk("async_rel", int'(rel), 0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 5; i++) smp(i, i - 1);
      @(negedge clk);
      clr = 1'b1;
      in_valid = 1'b1;
      in_count = 8'd50;
      @(posedge clk);
      #1;
      clr = 1'b0;
      in_valid = 1'b0;
      chk("clr_err", int'(err_count), 0);
      chk("clr_pulse", int'(err_pulse), 0);

      lastd = 0;
      m_pulses = 0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         clr = ($urandom_range(0, 99) == 0);
         in_valid = ($urandom_range(0, 4) != 0);
         c = ($urandom_range(0, 9) < 8) ? (lastd + 1) % 256 : int'($urandom_range(0, 255));
         if ($urandom_range(0, 19) == 0) c = lastd;
         case ($urandom_range(0, 2))
            0: p = (c + 255) % 256;
            1: p = c;
            default: p = int'($urandom_range(0, 255));
         endcase
         in_count = 8'(c);
         in_prev = 8'(p);
         if (in_valid) lastd = c;
         @(posedge clk);
         #1;
      end
      clr = 1'b0;
      in_valid = 1'b0;
      chk("random_saw_errors", int'(m_pulses > 0), 1);
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
